// File: rtl/pixel_streamer.sv
// pixel_streamer: raster-order feature-map reader with optional 1-pixel zero border,
// emitting a gap-free 64-bit beat stream aligned to a fixed-latency RAM read port.
module pixel_streamer #(
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [15:0]           cfg_img_width,
    input  logic [15:0]           cfg_img_height,
    input  logic [15:0]           cfg_in_channels,
    input  logic                  cfg_pad,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [63:0]           rd_data,
    output logic [63:0]           pixel_out,
    output logic                  pixel_out_valid,
    output logic                  pixel_out_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [16:0] wo_m1_q, ho_m1_q, x_q, x_d, y_q, y_d;
    logic [15:0] g_m1_q, g_q, g_d;
    logic pad_q, run, g_end, x_end, y_end, border, pos_last;
    logic [RD_LATENCY-1:0] iss_q, zero_q, last_q;
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        g_d      = g_q;
        x_d      = x_q;
        y_d      = y_q;
        run      = state_q == RUN;
        g_end    = g_q == g_m1_q;
        x_end    = x_q == wo_m1_q;
        y_end    = y_q == ho_m1_q;
        border   = pad_q & (x_q == '0 | x_end | y_q == '0 | y_end);
        pos_last = g_end & x_end & y_end;
        rd_en    = run & ~border;
        rd_addr  = rd_en ? ptr_q : '0;
        if (state_q == IDLE && go) begin
            state_d = RUN;
            ptr_d   = cfg_base_addr;
            g_d     = '0;
            x_d     = '0;
            y_d     = '0;
        end
        // Interior pixels are contiguous in memory, so one running pointer suffices.
        if (run) begin
            state_d = pos_last ? DRAIN : RUN;
            ptr_d   = ptr_q + ADDR_WIDTH'(rd_en);
            g_d     = g_end ? '0 : g_q + 16'd1;
            x_d     = g_end ? (x_end ? '0 : x_q + 17'd1) : x_q;
            y_d     = (g_end & x_end) ? y_q + 17'd1 : y_q;
        end
        if (state_q == DRAIN && iss_q[RD_LATENCY-1] && last_q[RD_LATENCY-1])
            state_d = DONE;
        if (state_q == DONE)
            state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wo_m1_q <= '0;
            ho_m1_q <= '0;
            g_m1_q  <= '0;
            pad_q   <= 1'b0;
            iss_q   <= '0;
            zero_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (state_q == IDLE && go) begin
                wo_m1_q <= {1'b0, cfg_img_width} + {15'd0, cfg_pad, 1'b0} - 17'd1;
                ho_m1_q <= {1'b0, cfg_img_height} + {15'd0, cfg_pad, 1'b0} - 17'd1;
                g_m1_q  <= (cfg_in_channels >> 3) - 16'd1;
                pad_q   <= cfg_pad;
            end
            iss_q  <= (iss_q << 1) | RD_LATENCY'(run);
            zero_q <= (zero_q << 1) | RD_LATENCY'(border);
            last_q <= (last_q << 1) | RD_LATENCY'(run & pos_last);
        end
    end
    assign busy            = state_q != IDLE;
    assign done            = state_q == DONE;
    assign pixel_out_valid = iss_q[RD_LATENCY-1];
    assign pixel_out_last  = iss_q[RD_LATENCY-1] & last_q[RD_LATENCY-1];
    assign pixel_out       = (iss_q[RD_LATENCY-1] & ~zero_q[RD_LATENCY-1]) ? rd_data : '0;
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: directed and random transfers on RD_LATENCY=2 and =1 instances,
// checked cycle by cycle against a raster-order model of the expected stream.
module tb_pixel_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] base = '0, w = 16'd1, h = 16'd1, c = 16'd8;
    logic pad = 1'b0, go2 = 1'b0, go1 = 1'b0, sel1 = 1'b0;
    logic busy2, done2, rden2, valid2, last2, busy1, done1, rden1, valid1, last1;
    logic [15:0] addr2, addr1;
    logic [63:0] rdata2, rdata1, pix2, pix1, s2a, s2b;
    logic o_busy, o_done, o_rden, o_valid, o_last;
    logic [15:0] o_addr;
    logic [63:0] o_pix;
    int n_assert = 0, n_fail = 0;
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_CAFE_F00D;

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_word(input logic [15:0] a);
        return {a ^ 16'hF00D, ~a, a ^ 16'h1234, a};
    endfunction

    // Behavioural RAMs: data for a read shows up RD_LATENCY cycles later; junk otherwise.
    always @(posedge clk) begin
        s2a    <= rden2 ? ram_word(addr2) : GARBAGE;
        s2b    <= s2a;
        rdata1 <= rden1 ? ram_word(addr1) : GARBAGE;
    end
    assign rdata2 = s2b;

    pixel_streamer #(.ADDR_WIDTH(16), .RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .cfg_base_addr(base), .cfg_img_width(w), .cfg_img_height(h),
        .cfg_in_channels(c), .cfg_pad(pad), .go(go2), .busy(busy2), .done(done2),
        .rd_en(rden2), .rd_addr(addr2), .rd_data(rdata2), .pixel_out(pix2),
        .pixel_out_valid(valid2), .pixel_out_last(last2));

    pixel_streamer #(.ADDR_WIDTH(16), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_base_addr(base), .cfg_img_width(w), .cfg_img_height(h),
        .cfg_in_channels(c), .cfg_pad(pad), .go(go1), .busy(busy1), .done(done1),
        .rd_en(rden1), .rd_addr(addr1), .rd_data(rdata1), .pixel_out(pix1),
        .pixel_out_valid(valid1), .pixel_out_last(last1));

    assign o_busy  = sel1 ? busy1 : busy2;
    assign o_done  = sel1 ? done1 : done2;
    assign o_rden  = sel1 ? rden1 : rden2;
    assign o_addr  = sel1 ? addr1 : addr2;
    assign o_valid = sel1 ? valid1 : valid2;
    assign o_last  = sel1 ? last1 : last2;
    assign o_pix   = sel1 ? pix1 : pix2;

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @go+%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_zero(input int d);
        chk("busy", d, 64'(o_busy), 0);
        chk("done", d, 64'(o_done), 0);
        chk("rd_en", d, 64'(o_rden), 0);
        chk("rd_addr", d, 64'(o_addr), 0);
        chk("valid", d, 64'(o_valid), 0);
        chk("last", d, 64'(o_last), 0);
        chk("pixel", d, o_pix, 0);
    endtask

    // Pulses go in the current cycle, then checks every cycle through go+N+L+2.
    // Also pokes go while busy and in the done cycle; both must be ignored.
    task automatic run_case(input bit l1, input int cw, input int ch, input int cc,
                            input bit cp, input logic [15:0] cb, input int rst_at);
        logic [63:0] beat [256];
        bit rden [256];
        logic [15:0] addr [256];
        int gg, wo, ho, n, lat, idx, p, i;
        bit bd, vexp;
        gg = cc / 8; p = int'(cp); wo = cw + 2 * p; ho = ch + 2 * p;
        n = wo * ho * gg; lat = l1 ? 1 : 2; idx = 0;
        for (int y = 0; y < ho; y++)
            for (int x = 0; x < wo; x++)
                for (int g = 0; g < gg; g++) begin
                    bd = cp && (x == 0 || x == wo - 1 || y == 0 || y == ho - 1);
                    addr[idx] = 16'(int'(cb) + ((y - p) * cw + (x - p)) * gg + g);
                    rden[idx] = !bd;
                    beat[idx] = bd ? 64'h0 : ram_word(addr[idx]);
                    idx++;
                end
        sel1 = l1; w = 16'(cw); h = 16'(ch); c = 16'(cc); pad = cp; base = cb;
        if (l1) go1 = 1'b1; else go2 = 1'b1;
        for (int d = 1; d <= n + lat + 2; d++) begin
            @(posedge clk); #1;
            go1 = 1'b0; go2 = 1'b0;
            rst = (d == rst_at);
            if (d == 3 || (rst_at == 0 && d == n + lat + 1)) begin
                if (l1) go1 = 1'b1; else go2 = 1'b1;
            end
            if (rst_at != 0 && d > rst_at) chk_zero(d);
            else begin
                i = d - 1 - lat;
                vexp = d >= 1 + lat && d <= n + lat;
                chk("busy", d, 64'(o_busy), 64'(d <= n + lat + 1));
                chk("done", d, 64'(o_done), 64'(d == n + lat + 1));
                chk("rd_en", d, 64'(o_rden), (d <= n) ? 64'(rden[d-1]) : 64'h0);
                if (d <= n && rden[d-1]) chk("rd_addr", d, 64'(o_addr), 64'(addr[d-1]));
                chk("valid", d, 64'(o_valid), 64'(vexp));
                chk("last", d, 64'(o_last), 64'(vexp && i == n - 1));
                chk("pixel", d, o_pix, vexp ? beat[i] : 64'h0);
            end
        end
        go1 = 1'b0; go2 = 1'b0;
    endtask

    initial begin
        logic [15:0] rb;
        repeat (3) @(posedge clk);
        #1;
        sel1 = 1'b0; chk_zero(0);
        sel1 = 1'b1; chk_zero(0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_case(0, 4, 3, 8, 0, 16'h0100, 0);
        run_case(0, 2, 2, 24, 0, 16'h0000, 0);
        run_case(0, 2, 2, 8, 1, 16'h0040, 0);
        run_case(0, 1, 1, 8, 0, 16'h0000, 0);
        run_case(0, 4, 3, 8, 0, 16'h0100, 6);
        repeat (2) @(posedge clk);
        #1;
        run_case(0, 4, 3, 8, 0, 16'h0100, 0);
        run_case(1, 4, 3, 8, 0, 16'h0100, 0);
        run_case(1, 1, 1, 8, 0, 16'h0200, 0);
        run_case(1, 2, 2, 8, 1, 16'h0040, 0);
        for (int r = 0; r < 10; r++) begin
            rb = (r == 4) ? 16'hFFFA : 16'($urandom);
            run_case(r % 3 == 0, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                     8 * int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), rb, 0);
            if (r % 2 == 1) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
